// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Function : Stream-loaded instruction RAM that holds riscv_cpu in reset until
//            a program is loaded. Define IMEM_LOADER_CHECKSUM_EN for a sum trailer.
// Revision : 1.0
// ============================================================================
module imem_loader #(
   parameter int          MEM_WORDS  = 1024,
   parameter int          ADDR_WIDTH = $clog2(MEM_WORDS),
   parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   output logic                  cpu_rst,
   input  logic [31:0]           instr_addr_i,
   output logic [31:0]           instr_data_o,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam logic [2:0] c_CLEAR = 3'd0;
   localparam logic [2:0] c_HDR   = 3'd1;
   localparam logic [2:0] c_DATA  = 3'd2;
   localparam logic [2:0] c_CSUM  = 3'd3;
   localparam logic [2:0] c_RUN   = 3'd4;
   localparam logic [2:0] c_ERR   = 3'd5;
   localparam logic [ADDR_WIDTH:0] c_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [2:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_clr_idx;
   logic [1:0]            r_byte_cnt;
   logic [23:0]           r_shift;
   logic [ADDR_WIDTH:0]   r_word_count;
   logic [ADDR_WIDTH:0]   r_words_loaded;
   logic [31:0]           mem [MEM_WORDS];

   logic                  w_xfer;
   logic                  w_last_byte;
   logic [31:0]           w_word;
   logic [2:0]            w_done_state;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [31:0]           w_wdata;
   logic                  w_addr_hi;

   assign s_ready      = (r_state == c_HDR) || (r_state == c_DATA) ||
                         (r_state == c_CSUM) || (r_state == c_ERR);
   assign cpu_rst      = (r_state != c_RUN);
   assign load_done    = (r_state == c_RUN);
   assign load_error   = (r_state == c_ERR);
   assign words_loaded = r_words_loaded;

   // load_start wins over a coincident byte, so the byte never counts as transferred
   assign w_xfer      = s_valid && s_ready && !load_start;
   assign w_last_byte = w_xfer && (r_byte_cnt == 2'd3);
   assign w_word      = {s_data, r_shift};

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] r_csum;
   assign w_done_state = c_CSUM;
`else
   assign w_done_state = c_RUN;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= c_CLEAR;
         r_clr_idx      <= '0;
         r_byte_cnt     <= 2'd0;
         r_shift        <= 24'd0;
         r_word_count   <= '0;
         r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum         <= 32'd0;
`endif
      end else if (load_start) begin
         r_state        <= c_CLEAR;
         r_clr_idx      <= '0;
         r_byte_cnt     <= 2'd0;
         r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum         <= 32'd0;
`endif
      end else begin
         if (w_xfer) begin
            r_shift    <= {s_data, r_shift[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
         end
         case (r_state)
            c_CLEAR: begin
               r_clr_idx <= r_clr_idx + 1'b1;
               if (&r_clr_idx)
                  r_state <= c_HDR;
            end
            c_HDR: begin
               if (w_last_byte) begin
                  if (w_word > 32'(MEM_WORDS))
                     r_state <= c_ERR;
                  else if (w_word == 32'd0)
                     r_state <= w_done_state;
                  else begin
                     r_word_count <= w_word[ADDR_WIDTH:0];
                     r_state      <= c_DATA;
                  end
               end
            end
            c_DATA: begin
               if (w_last_byte) begin
                  r_words_loaded <= r_words_loaded + c_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum <= r_csum + w_word;
`endif
                  if (r_words_loaded + c_ONE == r_word_count)
                     r_state <= w_done_state;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            c_CSUM: begin
               if (w_last_byte)
                  r_state <= (w_word == r_csum) ? c_RUN : c_ERR;
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_clr_idx;
      w_wdata = NOP_WORD;
      if (r_state == c_CLEAR) begin
         w_we = 1'b1;
      end else if ((r_state == c_DATA) && w_last_byte) begin
         w_we    = 1'b1;
         w_waddr = r_words_loaded[ADDR_WIDTH-1:0];
         w_wdata = w_word;
      end
   end

   // RAM is deliberately unreset; CLEAR owns its initialisation
   always_ff @(posedge clk) begin
      if (w_we)
         mem[w_waddr] <= w_wdata;
   end

   assign w_addr_hi    = ((instr_addr_i >> (ADDR_WIDTH + 2)) != 32'd0);
   assign instr_data_o = w_addr_hi ? NOP_WORD : mem[instr_addr_i[ADDR_WIDTH+1:2]];

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader and ROM replacement sitting directly upstream of `riscv_cpu`'s instruction port. It holds a synthesizable instruction RAM and fills it from a byte stream, for example a UART receiver. While it loads, it holds the CPU in reset, then releases the CPU to fetch from address 0. The instruction read port is combinational so the CPU's fetch timing is unchanged.

## Interface
Parameters:
- `MEM_WORDS`, 1024: instruction RAM depth in 32-bit words; power of two.
- `ADDR_WIDTH`, `$clog2(MEM_WORDS)`: word-index width.
- `NOP_WORD`, `32'h00000013`: fill and out-of-range read value (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `load_start` in 1: single-cycle pulse that restarts a load from any state.
- `s_valid` in 1: stream byte valid.
- `s_data` in 8: stream byte.
- `s_ready` out 1: loader accepts a byte; a transfer occurs when `s_valid && s_ready` at a rising edge.
- `cpu_rst` out 1: active-high reset to `riscv_cpu.rst`.
- `instr_addr_i` in 32: CPU fetch byte address.
- `instr_data_o` out 32: fetched word, combinational.
- `load_done` out 1: a program is loaded and the CPU is running.
- `load_error` out 1: the last load failed.
- `words_loaded` out `ADDR_WIDTH+1`: words written by the current or last load.

## Operation
- States: `CLEAR`, `HDR`, `DATA`, `CSUM`, `RUN`, `ERR`.
- Reset state is `CLEAR`. Reset values: `cpu_rst`=1, `s_ready`=0, `load_done`=0, `load_error`=0, `words_loaded`=0, all counters 0.
- RAM contents are not reset; `CLEAR` initialises them.
- `CLEAR`: writes `NOP_WORD` to word `clr_idx` each cycle for indices 0..`MEM_WORDS`-1, with `s_ready`=0, then goes to `HDR`.
- `HDR`: accepts 4 bytes, little-endian, giving the 32-bit word count N.
  - If N > `MEM_WORDS`: go to `ERR`.
  - If N = 0: go to `CSUM` (macro on) or `RUN` (macro off).
  - Otherwise go to `DATA`.
- `DATA`: assembles 4 bytes per word, little-endian (first byte is bits [7:0]).
  - On the 4th byte, writes RAM[`words_loaded`] and increments `words_loaded`.
  - After word N: go to `CSUM` (macro on) or `RUN` (macro off).
- `RUN`: `cpu_rst`=0, `load_done`=1, `s_ready`=0.
- `ERR`: `load_error`=1, `cpu_rst`=1, `s_ready`=1. Incoming bytes are discarded. Exit only via `load_start` or reset.
- `load_start` in any state:
  - Goes to `CLEAR`, clears `words_loaded`, `load_done`, `load_error` and the byte counter, and sets `cpu_rst`=1.
  - Takes priority over a simultaneous byte transfer; that byte is dropped.
- `s_ready` is 1 exactly in `HDR`, `DATA`, `CSUM` and `ERR`, decoded from state.
- Read port: `instr_data_o` = RAM[`instr_addr_i[ADDR_WIDTH+1:2]`].
  - `instr_addr_i[1:0]` are ignored.
  - If `instr_addr_i[31:ADDR_WIDTH+2]` is non-zero, the output is `NOP_WORD`.

## Timing
- Reset release to `HDR`: `MEM_WORDS` cycles. `s_ready` rises on the edge that writes the last clear word.
- Throughput: one byte per cycle. No back-pressure stalls inside `HDR`, `DATA` or `CSUM`.
- A RAM write happens on the edge that accepts the 4th byte of a word. The word is visible on `instr_data_o` in the following cycle.
- Completion:
  - `cpu_rst` falls and `load_done` rises on the edge that accepts the final stream byte (last data byte, or last checksum byte).
  - The CPU's first fetch is from address 0 in the next cycle.
- Asserting `rst_n` mid-load immediately forces all reset values. The partially written RAM is then overwritten by `CLEAR`.
- `load_start` while in `RUN`: `cpu_rst` rises on the next edge and the CPU is held until the new load completes.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the data words, `CSUM` accepts 4 little-endian bytes and compares them with the sum mod 2^32 of all N words.
  - On a match, the final byte edge enters `RUN`.
  - On a mismatch, the final byte edge enters `ERR` and the RAM keeps the loaded words.
- Not defined:
  - No `CSUM` state and no trailer bytes.
  - `load_error` is raised only for N > `MEM_WORDS`.

## Test plan
- Reset release with `s_valid`=0:
  - `cpu_rst`=1 throughout.
  - `s_ready` rises exactly 1024 cycles after `rst_n` rises.
  - Every address reads `32'h00000013`.
- Stream N=2, words `32'h00500093`, `32'h00A00113`, back-to-back (checksum `32'h00F001A6` if macro on):
  - Words read back at addresses 0x0 and 0x4.
  - `words_loaded`=2, `load_done`=1, `cpu_rst`=0 after the last byte.
  - Address 0x8 reads the NOP word.
- Stream with N=1025:
  - `load_error`=1 after the header and `cpu_rst` stays 1.
  - 100 further bytes are accepted and discarded.
  - A `load_start` pulse clears `load_error` and re-enters `CLEAR`.
- Macro on, N=1, word `32'h00000013`, checksum `32'h00000014`:
  - Enters `ERR` with `load_error`=1 and `cpu_rst`=1.
- Random `s_valid` gaps, `load_start` asserted in the same cycle as the 3rd data byte:
  - That byte is dropped, `words_loaded`=0 and `CLEAR` restarts.
  - A subsequent full load of N=4 succeeds.
- `rst_n` pulsed low for 1 cycle midway through `DATA`:
  - All outputs return to reset values immediately.
  - `instr_addr_i`=0x1000 always reads `32'h00000013`.
